// File: rtl/reg_mux_arbiter.sv
// Registered N-channel bus multiplexer with fixed-select or round-robin grant and valid/ready handshake.
// Optional packet locking is compiled in with `define MUX_LOCK_EN.
module reg_mux_arbiter #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
`ifdef MUX_LOCK_EN
    input  logic                      lock,
`endif
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    typedef enum logic {EMPTY, FULL} out_state_e;

    out_state_e        state_q, state_d;
    logic [SEL_W-1:0]  rr_last;
    logic [SEL_W-1:0]  grant;
    logic              grant_valid;
    logic              load;
    logic              accept;

`ifdef MUX_LOCK_EN
    logic              lock_q;
    logic [SEL_W-1:0]  lock_ch;
`endif

    // Handshake: a beat moves on a rising edge where valid and ready are both high; valid never waits on ready.
    assign out_valid = (state_q == FULL);
    assign load      = !out_valid || out_ready;
    assign accept    = load && grant_valid;

    always_comb begin
        logic [SEL_W-1:0] cand;
        grant_valid = 1'b0;
        grant       = '0;
        cand        = '0;
`ifdef MUX_LOCK_EN
        if (lock_q) begin
            grant_valid = in_valid[lock_ch];
            grant       = lock_ch;
        end else
`endif
        if (!mode) begin
            if (int'(sel) < CHANNELS) begin
                grant_valid = in_valid[sel];
                grant       = sel;
            end
        end else begin
            // Search starts one past the last winner so every requester is served in turn.
            for (int i = 1; i <= CHANNELS; i++) begin
                cand = SEL_W'((int'(rr_last) + i) % CHANNELS);
                if (!grant_valid && in_valid[cand]) begin
                    grant_valid = 1'b1;
                    grant       = cand;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && accept)
            in_ready = {{(CHANNELS-1){1'b0}}, 1'b1} << grant;
    end

    always_comb begin
        state_d = state_q;
        if (load)
            state_d = grant_valid ? FULL : EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_chan <= '0;
            rr_last  <= SEL_W'(CHANNELS - 1);
        end else if (accept) begin
            out_data <= in_data[int'(grant)*WIDTH +: WIDTH];
            out_chan <= grant;
            rr_last  <= grant;
        end
    end

`ifdef MUX_LOCK_EN
    // Only lock_ch can win while locked, so each accepted beat simply re-arms or releases the lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q  <= 1'b0;
            lock_ch <= '0;
        end else if (accept) begin
            lock_q  <= lock;
            lock_ch <= grant;
        end
    end
`endif

endmodule

// File: tb/tb_reg_mux_arbiter.sv
// Self-checking bench for reg_mux_arbiter: directed scenarios plus randomized traffic against a reference model.
// Lock scenarios are included when MUX_LOCK_EN is defined.
module tb_reg_mux_arbiter;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 2;

    logic                      clk;
    logic                      rst_n;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;
`ifdef MUX_LOCK_EN
    logic                      lock;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    reg_mux_arbiter #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
`ifdef MUX_LOCK_EN
        .lock      (lock),
`endif
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_valid   = 0;
    int m_data    = 0;
    int m_chan    = 0;
    int m_last    = CHANNELS - 1;
    int m_lock    = 0;
    int m_lock_ch = 0;

    function automatic int model_grant();
        if (m_lock != 0)
            return in_valid[m_lock_ch] ? m_lock_ch : -1;
        if (mode == 1'b0)
            return (int'(sel) < CHANNELS && in_valid[sel]) ? int'(sel) : -1;
        for (int d = 1; d <= CHANNELS; d++) begin
            int c;
            c = (m_last + d) % CHANNELS;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_data = 0; m_chan = 0; m_last = CHANNELS - 1;
            m_lock = 0; m_lock_ch = 0;
        end else if (m_valid == 0 || out_ready) begin
            int g;
            g = model_grant();
            if (g < 0) begin
                m_valid = 0;
            end else begin
                m_valid = 1;
                m_data  = int'(in_data[g*WIDTH +: WIDTH]);
                m_chan  = g;
                m_last  = g;
`ifdef MUX_LOCK_EN
                if (lock && m_lock == 0) begin
                    m_lock = 1; m_lock_ch = g;
                end else if (m_lock != 0 && g == m_lock_ch && !lock) begin
                    m_lock = 0;
                end
`endif
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every cycle, mid-low-phase: compare DUT against the model.
    always @(negedge clk) begin
        #2;
        begin
            logic [CHANNELS-1:0] exp_ready;
            int g;
            exp_ready = '0;
            g = model_grant();
            if (rst_n && (m_valid == 0 || out_ready) && g >= 0) exp_ready[g] = 1'b1;
            check("in_ready", 32'(in_ready), 32'(exp_ready));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid != 0) begin
                check("out_data", 32'(out_data), m_data);
                check("out_chan", 32'(out_chan), m_chan);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [SEL_W-1:0] t1_sel [4];
    logic [WIDTH-1:0] t1_exp [4];

    initial begin
        t1_sel = '{2'd0, 2'd1, 2'd3, 2'd2};
        t1_exp = '{8'h00, 8'hAA, 8'h55, 8'hFF};
        mode = 1'b1; sel = '0; in_valid = '1; out_ready = 1'b1;
        in_data = 32'h55FFAA00;
`ifdef MUX_LOCK_EN
        lock = 1'b0;
`endif
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        mode = 1'b0;
        rst_n = 1'b1;

        // fixed select sweep
        for (int i = 0; i < 4; i++) begin
            sel = t1_sel[i];
            after_edge();
            check("t1_data", 32'(out_data), 32'(t1_exp[i]));
            check("t1_chan", 32'(out_chan), 32'(t1_sel[i]));
            @(negedge clk);
        end

        // round-robin from reset, all requesting
        mode = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            after_edge();
            check("t2_chan", 32'(out_chan), 32'(i % 4));
            check("t2_valid", 32'(out_valid), 32'd1);
        end

        // two requesters alternate, then a single requester every cycle
        @(negedge clk);
        in_valid = 4'b1010;
        after_edge();
        begin
            int first;
            first = int'(out_chan);
            check("t3_first_is_1_or_3", 32'(first == 1 || first == 3), 32'd1);
            for (int i = 1; i < 5; i++) begin
                after_edge();
                check("t3_alt", 32'(out_chan), 32'(((i % 2) == 0) ? first : 4 - first));
            end
        end
        @(negedge clk);
        in_valid = 4'b0010;
        in_data  = 32'h44332211;
        for (int i = 0; i < 4; i++) begin
            after_edge();
            check("t3_single", 32'(out_chan), 32'd1);
            check("t3_single_valid", 32'(out_valid), 32'd1);
        end

        // stall: output holds, no input accepted
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            after_edge();
            if (i == 2) in_data = 32'h44339911;
            check("t4_hold_data", 32'(out_data), 32'h22);
            check("t4_hold_chan", 32'(out_chan), 32'd1);
            check("t4_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        after_edge();
        check("t4_resume", 32'(out_data), 32'h99);

        // fixed select on an idle channel drains the output
        @(negedge clk);
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1011;
        after_edge();
        check("t5_drain", 32'(out_valid), 32'd0);

        // asynchronous reset mid-stream
        @(negedge clk);
        mode = 1'b1; in_valid = 4'hF;
        after_edge();
        after_edge();
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(out_valid), 32'd0);
        check("t5_async_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        after_edge();
        check("t5_first_rr", 32'(out_chan), 32'd0);
        check("t5_first_valid", 32'(out_valid), 32'd1);

`ifdef MUX_LOCK_EN
        // locked three-beat packet from channel 2, then round-robin resumes
        do_reset();
        mode = 1'b1;
        in_valid = 4'b0100; lock = 1'b1;
        after_edge();
        check("t6_beat0", 32'(out_chan), 32'd2);
        @(negedge clk);
        in_valid = 4'b0111; lock = 1'b1;
        after_edge();
        check("t6_beat1", 32'(out_chan), 32'd2);
        @(negedge clk);
        lock = 1'b0;
        after_edge();
        check("t6_beat2", 32'(out_chan), 32'd2);
        after_edge();
        check("t6_resume", 32'(out_chan), 32'd0);
        @(negedge clk);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            mode      = 1'($urandom_range(0, 1));
            sel       = SEL_W'($urandom_range(0, CHANNELS - 1));
            in_valid  = CHANNELS'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
`ifdef MUX_LOCK_EN
            lock      = ($urandom_range(0, 3) == 0);
`endif
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        #4;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
